// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell walks two captured operands LSB-first,
// producing the registered WIDTH-bit sum and carry-out with a one-cycle done pulse.

module full_adder (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic Sout,
  output logic Cout
);
  assign Sout = Ain ^ Bin ^ Cin;
  assign Cout = (Ain & Bin) | (Ain & Cin) | (Bin & Cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, a_sh_next;
  logic [WIDTH-1:0] b_sh, b_sh_next;
  logic [WIDTH-1:0] s_sh, s_sh_next;
  logic [WIDTH-1:0] sum_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             carry, carry_next;
  logic             cout_next, busy_next, done_next;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .Ain  (a_sh[0]),
    .Bin  (b_sh[0]),
    .Cin  (carry),
    .Sout (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_next = state;
    a_sh_next  = a_sh;
    b_sh_next  = b_sh;
    s_sh_next  = s_sh;
    sum_next   = sum;
    cnt_next   = cnt;
    carry_next = carry;
    cout_next  = cout;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_sh_next  = a_in;
          b_sh_next  = b_in;
          carry_next = cin;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        s_sh_next  = {fa_sum, s_sh[WIDTH-1:1]};
        carry_next = fa_cout;
        a_sh_next  = a_sh >> 1;
        b_sh_next  = b_sh >> 1;
        cnt_next   = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          sum_next   = {fa_sum, s_sh[WIDTH-1:1]};
          cout_next  = fa_cout;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      a_sh  <= a_sh_next;
      b_sh  <= b_sh_next;
      s_sh  <= s_sh_next;
      sum   <= sum_next;
      cnt   <= cnt_next;
      carry <= carry_next;
      cout  <= cout_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end
endmodule
